// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, the mul/div engine state encoding and the default datapath width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 64;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_MUL = 4'd6,
    ALU_DIV = 4'd7
  } Alu_Op;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative mul/div datapath: 2W-bit accumulator (product, or remainder:quotient), one shift-add
// or restoring shift-subtract step per cycle, and the final sign-correction muxes.
module muldiv_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_loadDivZero,
  input  muldiv_op_e       i_loadOp,
  input  logic [WIDTH-1:0] i_rawR,
  input  logic [WIDTH-1:0] i_magR,
  input  logic [WIDTH-1:0] i_magS,
  input  logic             i_step,
  input  muldiv_op_e       i_op,
  input  logic             i_bypassFix,
  input  logic             i_negLo,
  input  logic             i_negHi,
  output logic [WIDTH-1:0] o_fixLo,
  output logic [WIDTH-1:0] o_fixHi
);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_operand;

  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH:0]     w_mulSum;
  logic [2*WIDTH-1:0] w_mulNext;
  logic [WIDTH:0]     w_trial;
  logic               w_divOk;
  logic [2*WIDTH-1:0] w_divNext;
  logic [2*WIDTH-1:0] w_negProd;

  assign w_hi = r_acc[2*WIDTH-1:WIDTH];
  assign w_lo = r_acc[WIDTH-1:0];

  // MUL: low half holds the not-yet-consumed multiplier bits; the carry rides into the shift.
  assign w_mulSum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_operand} : {(WIDTH+1){1'b0}});
  assign w_mulNext = {w_mulSum, w_lo[WIDTH-1:1]};

  // DIV: the partial remainder is always below the divisor, so the shifted trial fits in W+1 bits.
  assign w_trial   = {w_hi, w_lo[WIDTH-1]} - {1'b0, r_operand};
  assign w_divOk   = ~w_trial[WIDTH];
  assign w_divNext = w_divOk ? {w_trial[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b1}
                             : {w_hi[WIDTH-2:0], w_lo[WIDTH-1], w_lo[WIDTH-2:0], 1'b0};

  assign w_negProd = -r_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      r_operand <= '0;
    end else if (i_load) begin
      if (i_loadDivZero) begin
        r_acc     <= {i_rawR, {WIDTH{1'b1}}};
        r_operand <= '0;
      end else if (i_loadOp == OP_MUL) begin
        r_acc     <= {{WIDTH{1'b0}}, i_magS};
        r_operand <= i_magR;
      end else begin
        r_acc     <= {{WIDTH{1'b0}}, i_magR};
        r_operand <= i_magS;
      end
    end else if (i_step) begin
      r_acc <= (i_op == OP_MUL) ? w_mulNext : w_divNext;
    end
  end

  always_comb begin
    o_fixLo = w_lo;
    o_fixHi = w_hi;
    if (!i_bypassFix) begin
      if (i_op == OP_MUL) begin
        if (i_negLo) begin
          o_fixHi = w_negProd[2*WIDTH-1:WIDTH];
          o_fixLo = w_negProd[WIDTH-1:0];
        end
      end else begin
        if (i_negLo) o_fixLo = -w_lo;
        if (i_negHi) o_fixHi = -w_hi;
      end
    end
  end

endmodule

// File: rtl/iter_muldiv_unit.sv
// Multi-cycle signed multiply/divide engine with a start/done handshake; owns the FSM,
// iteration counter and result/flag registers around muldiv_datapath.
module iter_muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] S,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y_lo,
  output logic [WIDTH-1:0] Y_hi,
  output logic             div_by_zero,
  output logic             N,
  output logic             Z
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  muldiv_state_e    r_state;
  muldiv_state_e    w_nextState;
  logic [CW-1:0]    r_count;
  muldiv_op_e       r_op;
  logic             r_signDiff;
  logic             r_signR;
  logic             r_divZero;

  logic             w_accept;
  logic             w_divZero;
  logic             w_load;
  logic             w_step;
  logic             w_finish;
  logic [WIDTH-1:0] w_magR;
  logic [WIDTH-1:0] w_magS;
  logic [WIDTH-1:0] w_fixLo;
  logic [WIDTH-1:0] w_fixHi;

  assign w_accept  = (r_state == IDLE) && start;
  assign w_divZero = w_accept && (op == OP_DIV) && (S == '0);
  assign w_magR    = R[WIDTH-1] ? -R : R;
  assign w_magS    = S[WIDTH-1] ? -S : S;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_nextState = w_divZero ? FIX : CALC;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (r_count == LAST_STEP) w_nextState = FIX;
      end
      FIX: begin
        w_finish    = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Results and flags change only on an accepted start (flag clear) or in FIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_op        <= OP_MUL;
      r_signDiff  <= 1'b0;
      r_signR     <= 1'b0;
      r_divZero   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Y_lo        <= '0;
      Y_hi        <= '0;
      div_by_zero <= 1'b0;
      N           <= 1'b0;
      Z           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_load) begin
        r_count     <= '0;
        r_op        <= muldiv_op_e'(op);
        r_signDiff  <= R[WIDTH-1] ^ S[WIDTH-1];
        r_signR     <= R[WIDTH-1];
        r_divZero   <= w_divZero;
        busy        <= 1'b1;
        div_by_zero <= 1'b0;
      end else if (w_step) begin
        r_count <= r_count + 1'b1;
      end
      if (w_finish) begin
        busy        <= 1'b0;
        done        <= 1'b1;
        Y_lo        <= w_fixLo;
        Y_hi        <= w_fixHi;
        div_by_zero <= r_divZero;
        if (r_op == OP_MUL) begin
          N <= w_fixHi[WIDTH-1];
          Z <= ({w_fixHi, w_fixLo} == '0);
        end else begin
          N <= w_fixLo[WIDTH-1];
          Z <= (w_fixLo == '0);
        end
      end
    end
  end

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load),
    .i_loadDivZero(w_divZero),
    .i_loadOp     (muldiv_op_e'(op)),
    .i_rawR       (R),
    .i_magR       (w_magR),
    .i_magS       (w_magS),
    .i_step       (w_step),
    .i_op         (r_op),
    .i_bypassFix  (r_divZero),
    .i_negLo      (r_signDiff),
    .i_negHi      (r_signR),
    .o_fixLo      (w_fixLo),
    .o_fixHi      (w_fixHi)
  );

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Scoreboard bench for iter_muldiv_unit: expected results come from plain 128-bit signed arithmetic.
module tb_iter_muldiv_unit;

  localparam int W = 64;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic         clk;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] R;
  logic [W-1:0] S;
  logic         busy;
  logic         done;
  logic [W-1:0] Y_lo;
  logic [W-1:0] Y_hi;
  logic         div_by_zero;
  logic         N;
  logic         Z;

  typedef struct {
    logic [W-1:0] yLo;
    logic [W-1:0] yHi;
    logic         dbz;
    logic         n;
    logic         z;
    int           latency;
    int           issueCycle;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  iter_muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .R          (R),
    .S          (S),
    .busy       (busy),
    .done       (done),
    .Y_lo       (Y_lo),
    .Y_hi       (Y_hi),
    .div_by_zero(div_by_zero),
    .N          (N),
    .Z          (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference: full-precision signed arithmetic, truncating division, fixed divide-by-zero result.
  function automatic exp_t computeExpected(input logic o, input logic [W-1:0] r, input logic [W-1:0] s);
    exp_t e;
    logic signed [127:0] a;
    logic signed [127:0] b;
    logic signed [127:0] p;
    logic signed [127:0] qt;
    logic signed [127:0] rm;
    a = {{W{r[W-1]}}, r};
    b = {{W{s[W-1]}}, s};
    e.issueCycle = 0;
    if (o == 1'b0) begin
      p = a * b;
      e.yLo = p[W-1:0];
      e.yHi = p[127:W];
      e.dbz = 1'b0;
      e.n   = p[127];
      e.z   = (p == 0);
      e.latency = W + 1;
    end else if (s == '0) begin
      e.yLo = '1;
      e.yHi = r;
      e.dbz = 1'b1;
      e.n   = 1'b1;
      e.z   = 1'b0;
      e.latency = 1;
    end else begin
      qt = a / b;
      rm = a % b;
      e.yLo = qt[W-1:0];
      e.yHi = rm[W-1:0];
      e.dbz = 1'b0;
      e.n   = qt[W-1];
      e.z   = (qt[W-1:0] == '0);
      e.latency = W + 1;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no pending operation (cycle %0d)", cycle);
      end else begin
        e = expQ.pop_front();
        checkOutput("Y_lo", 128'(Y_lo), 128'(e.yLo));
        checkOutput("Y_hi", 128'(Y_hi), 128'(e.yHi));
        checkOutput("div_by_zero", 128'(div_by_zero), 128'(e.dbz));
        checkOutput("N", 128'(N), 128'(e.n));
        checkOutput("Z", 128'(Z), 128'(e.z));
        checkOutput("busy_at_done", 128'(busy), 128'(0));
        checkOutput("latency", 128'(cycle - e.issueCycle), 128'(e.latency));
      end
    end
  end

  task automatic applyStimulus(input logic o, input logic [W-1:0] r, input logic [W-1:0] s);
    exp_t e;
    e = computeExpected(o, r, s);
    op    = o;
    R     = r;
    S     = s;
    start = 1'b1;
    @(posedge clk);
    #2;
    e.issueCycle = cycle;
    expQ.push_back(e);
    start = 1'b0;
    R = {$urandom, $urandom};
    S = {$urandom, $urandom};
    checkOutput("busy_after_start", 128'(busy), 128'(1));
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200; i++) begin
      if (expQ.size() == 0 && busy == 1'b0) break;
      @(posedge clk);
      #2;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got %0d pending results expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic waitDoneCycle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_wait_timeout: got no done expected a done pulse");
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] rr;
    logic [W-1:0] ss;
    logic         oo;
    int           mode;
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    R     = '0;
    S     = '0;
    #12;
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_done", 128'(done), 128'(0));
    checkOutput("reset_Y_lo", 128'(Y_lo), 128'(0));
    checkOutput("reset_Y_hi", 128'(Y_hi), 128'(0));
    checkOutput("reset_dbz", 128'(div_by_zero), 128'(0));
    checkOutput("reset_N", 128'(N), 128'(0));
    checkOutput("reset_Z", 128'(Z), 128'(0));
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #2;

    $display("[TB] MUL 3 * -5");
    applyStimulus(1'b0, 64'd3, -64'sd5);
    waitIdle();
    checkOutput("t1_Y_lo_const", 128'(Y_lo), 128'(64'hFFFF_FFFF_FFFF_FFF1));
    checkOutput("t1_Y_hi_const", 128'(Y_hi), 128'(64'hFFFF_FFFF_FFFF_FFFF));

    $display("[TB] DIV -7 / 2 and 7 / -2");
    applyStimulus(1'b1, -64'sd7, 64'd2);
    waitIdle();
    checkOutput("t2_quot_const", 128'(Y_lo), 128'(64'hFFFF_FFFF_FFFF_FFFD));
    applyStimulus(1'b1, 64'd7, -64'sd2);
    waitIdle();
    checkOutput("t2_rem_const", 128'(Y_hi), 128'(64'd1));

    $display("[TB] DIV 5 / 0 then valid start");
    applyStimulus(1'b1, 64'd5, 64'd0);
    waitIdle();
    checkOutput("t3_hold_dbz", 128'(div_by_zero), 128'(1));
    applyStimulus(1'b1, 64'd100, 64'd7);
    checkOutput("t3_dbz_cleared", 128'(div_by_zero), 128'(0));
    waitIdle();

    $display("[TB] MIN / -1 and MIN * MIN");
    applyStimulus(1'b1, MIN_VAL, '1);
    waitIdle();
    checkOutput("t4_min_div_const", 128'(Y_lo), 128'(MIN_VAL));
    applyStimulus(1'b0, MIN_VAL, MIN_VAL);
    waitIdle();
    checkOutput("t4_min_mul_const", 128'(Y_hi), 128'(64'h4000_0000_0000_0000));

    $display("[TB] start while busy, then start in done cycle");
    applyStimulus(1'b0, 64'd123456789, -64'sd987654321);
    repeat (9) @(posedge clk);
    #2;
    op    = 1'b1;
    R     = 64'd77;
    S     = 64'd0;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    op    = 1'b0;
    waitDoneCycle();
    applyStimulus(1'b1, -64'sd1000, 64'd33);
    waitIdle();

    $display("[TB] reset in the middle of a DIV");
    applyStimulus(1'b1, 64'd999999, 64'd13);
    repeat (29) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    expQ.delete();
    checkOutput("t6_busy", 128'(busy), 128'(0));
    checkOutput("t6_done", 128'(done), 128'(0));
    checkOutput("t6_Y_lo", 128'(Y_lo), 128'(0));
    checkOutput("t6_Y_hi", 128'(Y_hi), 128'(0));
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (70) @(posedge clk);
    #2;
    applyStimulus(1'b0, 64'd0, 64'd9);
    waitIdle();
    checkOutput("t6_zero_Z", 128'(Z), 128'(1));

    $display("[TB] randomized operations");
    for (int k = 0; k < 30; k++) begin
      oo   = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin
          rr = {$urandom, $urandom};
          ss = {$urandom, $urandom};
        end
        1: begin
          rr = 64'(longint'($urandom_range(0, 200)) - 100);
          ss = 64'(longint'($urandom_range(0, 200)) - 100);
        end
        2: begin
          rr = {$urandom, $urandom};
          ss = 64'(longint'($urandom_range(0, 6)) - 3);
        end
        default: begin
          rr = ($urandom_range(0, 1) == 0) ? MIN_VAL : ~MIN_VAL;
          ss = ($urandom_range(0, 1) == 0) ? '1 : {32'h0, $urandom};
        end
      endcase
      applyStimulus(oo, rr, ss);
      waitIdle();
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
